// File: rtl/fm_padding_stream_if.sv
// Valid/ready beat stream used on both sides of the padding stage.
// The master drives valid and data, and the slave drives ready.
interface fm_padding_stream_if #(
  parameter int DW = 8
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/fm_padding_stream.sv
// fm_padding_stream: streaming zero-padding stage for the conv pipeline.
// Takes a row-major feature map with channel folds innermost and emits the
// padded map. Zero beats are inserted at border positions without consuming
// any input. A single output holding register gives a 1-cycle latency and
// full-rate throughput.
// Optional feature: FM_PADDING_FRAME_CNT_EN adds a 32-bit frames_done port
// that counts frames whose final beat has been accepted downstream.
module fm_padding_stream #(
  parameter int BIT_WIDTH  = 8,
  parameter int SIMD       = 1,
  parameter int CHANNELS   = 1,
  parameter int IN_H       = 4,
  parameter int IN_W       = 4,
  parameter int PAD_TOP    = 1,
  parameter int PAD_BOTTOM = 1,
  parameter int PAD_LEFT   = 1,
  parameter int PAD_RIGHT  = 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  fm_padding_stream_if.slave   in0_V,
  fm_padding_stream_if.master  out_V
`ifdef FM_PADDING_FRAME_CNT_EN
  ,
  output logic [31:0]          frames_done
`endif
);

  localparam int FOLDS  = CHANNELS / SIMD;
  localparam int OUT_H  = IN_H + PAD_TOP + PAD_BOTTOM;
  localparam int OUT_W  = IN_W + PAD_LEFT + PAD_RIGHT;
  localparam int DW     = BIT_WIDTH * SIMD;
  // A counter whose maximum is 0 still needs one bit to exist.
  localparam int FOLD_W = (FOLDS > 1) ? $clog2(FOLDS) : 1;
  localparam int X_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int Y_W    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  logic [FOLD_W-1:0] fold;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic              out_valid_q;
  logic [DW-1:0]     out_data_q;
  logic              is_pad;
  logic              load_ok;
  logic              gen;
  logic              last_fold;
  logic              last_x;
  logic              last_y;

  // Comparisons are done in int so that bounds such as PAD_TOP+IN_H never
  // overflow the narrow counter widths.
  assign is_pad = (int'(y) < PAD_TOP) || (int'(y) >= PAD_TOP + IN_H) ||
                  (int'(x) < PAD_LEFT) || (int'(x) >= PAD_LEFT + IN_W);

  assign last_fold = (int'(fold) == FOLDS - 1);
  assign last_x    = (int'(x) == OUT_W - 1);
  assign last_y    = (int'(y) == OUT_H - 1);

  assign load_ok = !out_valid_q || out_V.tready;
  assign gen     = load_ok && (is_pad || in0_V.tvalid);

  // Ready is deliberately independent of tvalid. It is forced low while in reset.
  assign in0_V.tready = ap_rst_n && load_ok && !is_pad;
  assign out_V.tvalid = out_valid_q;
  assign out_V.tdata  = out_data_q;

  // Output holding register: load on generate, drop valid once taken with nothing new.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (gen) begin
      out_valid_q <= 1'b1;
      out_data_q  <= is_pad ? '0 : in0_V.tdata;
    end else if (out_V.tready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Position counters: fold innermost, then x, then y. They wrap into the next frame with no gap.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      fold <= '0;
      x    <= '0;
      y    <= '0;
    end else if (gen) begin
      if (last_fold) begin
        fold <= '0;
        if (last_x) begin
          x <= '0;
          y <= last_y ? '0 : y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end else begin
        fold <= fold + FOLD_W'(1);
      end
    end
  end

`ifdef FM_PADDING_FRAME_CNT_EN
  logic out_last_q;

  // Tag the held beat as frame-final, and count when that beat is accepted.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_last_q  <= 1'b0;
      frames_done <= '0;
    end else begin
      if (gen) out_last_q <= last_fold && last_x && last_y;
      if (out_valid_q && out_V.tready && out_last_q) frames_done <= frames_done + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fm_padding_stream.sv
// Testbench for fm_padding_stream: a 2x2 map with 1-pixel pads (one fold and
// two folds) and a 3x3 pass-through with no padding.
module tb_fm_padding_stream;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_pass  = 0;
  int n_total = 0;

  fm_padding_stream_if #(.DW(8)) a_in(), a_out(), b_in(), b_out(), c_in(), c_out();

`ifdef FM_PADDING_FRAME_CNT_EN
  logic [31:0] a_frames, b_frames, c_frames;
`endif

  fm_padding_stream #(.IN_H(2), .IN_W(2), .CHANNELS(1)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in0_V(a_in), .out_V(a_out)
`ifdef FM_PADDING_FRAME_CNT_EN
    , .frames_done(a_frames)
`endif
  );

  fm_padding_stream #(.IN_H(2), .IN_W(2), .CHANNELS(2)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in0_V(b_in), .out_V(b_out)
`ifdef FM_PADDING_FRAME_CNT_EN
    , .frames_done(b_frames)
`endif
  );

  fm_padding_stream #(.IN_H(3), .IN_W(3), .PAD_TOP(0), .PAD_BOTTOM(0),
                      .PAD_LEFT(0), .PAD_RIGHT(0)) dut_c (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in0_V(c_in), .out_V(c_out)
`ifdef FM_PADDING_FRAME_CNT_EN
    , .frames_done(c_frames)
`endif
  );

  typedef struct {
    logic [7:0] din;
    logic       exp_rdy;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t       tbl[16];
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: walk the padded frame and take input only where the position is inside the map.
  task automatic model_frame(input int ih, input int iw, input int pt, input int pb,
                             input int pl, input int pr, input int folds);
    for (int yy = 0; yy < ih + pt + pb; yy++)
      for (int xx = 0; xx < iw + pl + pr; xx++)
        for (int f = 0; f < folds; f++)
          if (yy < pt || yy >= pt + ih || xx < pl || xx >= pl + iw) exp_q.push_back(8'h00);
          else exp_q.push_back(src_q.pop_front());
  endtask

  task automatic idle_inputs();
    a_in.tvalid = 0; a_in.tdata = 0; a_out.tready = 0;
    b_in.tvalid = 0; b_in.tdata = 0; b_out.tready = 0;
    c_in.tvalid = 0; c_in.tdata = 0; c_out.tready = 0;
  endtask

  task automatic do_reset();
    ap_rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1;
  endtask

  task automatic run_table(input int ncyc, input string tag);
    a_out.tready = 1;
    a_in.tvalid  = 1;
    for (int k = 0; k < ncyc; k++) begin
      a_in.tdata = tbl[k].din;
      @(negedge ap_clk);
      check({tag, "_rdy"}, a_in.tready, tbl[k].exp_rdy);
      @(posedge ap_clk); #1;
      check({tag, "_vld"}, a_out.tvalid, 1);
      check({tag, "_dat"}, a_out.tdata, tbl[k].exp_dout);
    end
  endtask

  initial begin
    int         din_v[16]  = '{1,1,1,1,1,1,2,3,3,3,4,0,0,0,0,0};
    int         rdy_v[16]  = '{0,0,0,0,0,1,1,0,0,1,1,0,0,0,0,0};
    int         dout_v[16] = '{0,0,0,0,0,1,2,0,0,3,4,0,0,0,0,0};
    logic [7:0] in_q[$];
    logic       prev_stall;
    logic [7:0] prev_data;
    int         cyc;

    for (int k = 0; k < 16; k++) begin
      tbl[k].din      = 8'(din_v[k]);
      tbl[k].exp_rdy  = rdy_v[k][0];
      tbl[k].exp_dout = 8'(dout_v[k]);
    end

    idle_inputs();
    #12;
    check("rst_a_vld", a_out.tvalid, 0);
    check("rst_a_dat", a_out.tdata, 0);
    check("rst_c_rdy", c_in.tready, 0);
    @(posedge ap_clk); #1 ap_rst_n = 1;

    // Full-rate 2x2 frame with 1-pixel pads.
    run_table(16, "full");

    // An asynchronous reset after 5 beats must discard the partial frame.
    do_reset();
    run_table(5, "pre");
    #2 ap_rst_n = 0;
    #1;
    check("async_vld", a_out.tvalid, 0);
    check("async_dat", a_out.tdata, 0);
    check("async_rdy", a_in.tready, 0);
    @(posedge ap_clk); #1 ap_rst_n = 1;
    run_table(16, "restart");

    // Random input gaps and random backpressure over two frames.
    do_reset();
    src_q.delete(); exp_q.delete(); in_q.delete();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(1, 255));
      src_q.push_back(v);
      in_q.push_back(v);
    end
    model_frame(2, 2, 1, 1, 1, 1, 1);
    model_frame(2, 2, 1, 1, 1, 1, 1);
    prev_stall = 0; prev_data = 0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      a_in.tvalid  = (in_q.size() > 0) && ($urandom_range(0, 2) != 0);
      a_in.tdata   = (in_q.size() > 0) ? in_q[0] : 8'h00;
      a_out.tready = 1'($urandom_range(0, 1));
      @(negedge ap_clk);
      if (prev_stall) begin
        check("stall_vld", a_out.tvalid, 1);
        check("stall_dat", a_out.tdata, prev_data);
      end
      if (a_out.tvalid && !a_out.tready) check("bp_rdy", a_in.tready, 0);
      if (a_out.tvalid && a_out.tready) check("rnd_dat", a_out.tdata, exp_q.pop_front());
      if (a_in.tvalid && a_in.tready) void'(in_q.pop_front());
      prev_stall = a_out.tvalid && !a_out.tready;
      prev_data  = a_out.tdata;
      @(posedge ap_clk); #1;
      cyc++;
    end
    check("rnd_done", exp_q.size(), 0);

    // Two folds per pixel: pad pixels give two zero beats, and data folds stay in order.
    do_reset();
    src_q.delete(); exp_q.delete(); in_q.delete();
    for (int i = 0; i < 8; i++) begin
      src_q.push_back(8'(8'hA0 + (i / 2) * 16 + (i % 2)));
      in_q.push_back(8'(8'hA0 + (i / 2) * 16 + (i % 2)));
    end
    model_frame(2, 2, 1, 1, 1, 1, 2);
    b_out.tready = 1;
    b_in.tvalid  = 1;
    for (int k = 0; k < 32; k++) begin
      b_in.tdata = (in_q.size() > 0) ? in_q[0] : 8'h00;
      @(negedge ap_clk);
      if (b_in.tvalid && b_in.tready) void'(in_q.pop_front());
      @(posedge ap_clk); #1;
      check("fold_vld", b_out.tvalid, 1);
      check("fold_dat", b_out.tdata, exp_q.pop_front());
    end
    check("fold_used", in_q.size(), 0);

    // No padding: 3x3 pass-through with 1-cycle latency and no bubbles.
    do_reset();
    c_out.tready = 1;
    c_in.tvalid  = 1;
    for (int k = 0; k < 9; k++) begin
      c_in.tdata = 8'(8'h10 + k);
      @(negedge ap_clk);
      check("pt_rdy", c_in.tready, 1);
      @(posedge ap_clk); #1;
      check("pt_vld", c_out.tvalid, 1);
      check("pt_dat", c_out.tdata, 8'(8'h10 + k));
    end
    c_in.tvalid = 0;
    @(posedge ap_clk); #1;
    check("starve_vld", c_out.tvalid, 0);

`ifdef FM_PADDING_FRAME_CNT_EN
    // Two back-to-back frames: the count steps on the accept of each final beat.
    begin
      int accepted;
      do_reset();
      accepted = 0;
      a_out.tready = 1;
      a_in.tvalid  = 1;
      for (int k = 0; k < 34; k++) begin
        a_in.tdata = 8'(k + 1);
        @(negedge ap_clk);
        if (a_out.tvalid && a_out.tready) accepted++;
        @(posedge ap_clk); #1;
        check("frames", a_frames, 32'(accepted / 16));
        check("b2b_vld", a_out.tvalid, 1);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
